// File: rtl/exunit_alu_pipe.sv
// Pipelined integer ALU execution unit.
// The ALU result is computed at issue. The result, destination tag and
// speculation state then travel through LATENCY register stages to the
// RRF/ROB writeback port. Speculative entries are killed on a matching
// mispredict. Their spec bit is dropped on a matching correct prediction.
module exunit_alu_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int SPECTAG_W = 5,
    parameter int RRF_W     = 6,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue,
    input  logic [DATA_W-1:0]    ex_src1,
    input  logic [DATA_W-1:0]    ex_src2,
    input  logic [ADDR_W-1:0]    pc,
    input  logic [DATA_W-1:0]    imm,
    input  logic                 src_a_sel,
    input  logic                 src_b_sel,
    input  logic [3:0]           alu_op,
    input  logic                 dstval,
    input  logic [RRF_W-1:0]     rrftag,
    input  logic [SPECTAG_W-1:0] spectag,
    input  logic                 specbit,
    input  logic                 prmiss,
    input  logic                 prsuccess,
    input  logic [SPECTAG_W-1:0] spectagfix,
    output logic [DATA_W-1:0]    result,
    output logic [RRF_W-1:0]     out_rrftag,
    output logic                 rrf_we,
    output logic                 rob_we,
    output logic                 busy
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int LAST = LATENCY - 1;

    function automatic logic tag_match(input logic [SPECTAG_W-1:0] tag,
                                       input logic [SPECTAG_W-1:0] fix);
        return |(tag & fix);
    endfunction

    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [SH_W-1:0]   shamt;

    // The PC is fitted to the datapath width: truncated if wider, zero-extended if narrower.
    generate
        if (ADDR_W >= DATA_W) begin : g_pc_trunc
            assign pc_ext = pc[DATA_W-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DATA_W-ADDR_W){1'b0}}, pc};
        end
    endgenerate

    assign op_a  = src_a_sel ? pc_ext : ex_src1;
    assign op_b  = src_b_sel ? imm : ex_src2;
    assign shamt = op_b[SH_W-1:0];

    // ALU datapath for the issuing instruction.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:  alu_res = op_a + op_b;
            4'd1:  alu_res = op_a - op_b;
            4'd2:  alu_res = op_a & op_b;
            4'd3:  alu_res = op_a | op_b;
            4'd4:  alu_res = op_a ^ op_b;
            4'd5:  alu_res = op_a << shamt;
            4'd6:  alu_res = op_a >> shamt;
            4'd7:  alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd9:  alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            4'd10: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Per-stage state. Index 0 is loaded at issue and index LAST drives writeback.
    logic [LATENCY-1:0]                vld_q, vld_d;
    logic [LATENCY-1:0]                dst_q, dst_d;
    logic [LATENCY-1:0]                spec_q, spec_d;
    logic [LATENCY-1:0][DATA_W-1:0]    res_q, res_d;
    logic [LATENCY-1:0][RRF_W-1:0]     rtag_q, rtag_d;
    logic [LATENCY-1:0][SPECTAG_W-1:0] stag_q, stag_d;

    // A simultaneous mispredict takes priority, so a correct prediction only
    // clears spec bits when no mispredict is resolving.
    logic clr_spec;
    assign clr_spec = prsuccess & ~prmiss;

    // Next state for each stage: advance one slot each cycle with kill and spec-clear applied.
    always_comb begin
        vld_d     = '0;
        dst_d     = '0;
        spec_d    = '0;
        res_d     = '0;
        rtag_d    = '0;
        stag_d    = '0;
        vld_d[0]  = issue & ~(prmiss & specbit & tag_match(spectag, spectagfix));
        dst_d[0]  = dstval;
        spec_d[0] = specbit & ~(clr_spec & tag_match(spectag, spectagfix));
        res_d[0]  = alu_res;
        rtag_d[0] = rrftag;
        stag_d[0] = spectag;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k]  = vld_q[k-1] & ~(prmiss & spec_q[k-1] & tag_match(stag_q[k-1], spectagfix));
            dst_d[k]  = dst_q[k-1];
            spec_d[k] = spec_q[k-1] & ~(clr_spec & tag_match(stag_q[k-1], spectagfix));
            res_d[k]  = res_q[k-1];
            rtag_d[k] = rtag_q[k-1];
            stag_d[k] = stag_q[k-1];
        end
    end

    // Pipe registers. There is no stall, so every stage loads on every clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            dst_q  <= '0;
            spec_q <= '0;
            res_q  <= '0;
            rtag_q <= '0;
            stag_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dst_q  <= dst_d;
            spec_q <= spec_d;
            res_q  <= res_d;
            rtag_q <= rtag_d;
            stag_q <= stag_d;
        end
    end

    // The output stage is qualified against a mispredict resolving in the writeback cycle.
    assign rob_we     = vld_q[LAST] & ~(prmiss & spec_q[LAST] & tag_match(stag_q[LAST], spectagfix));
    assign rrf_we     = rob_we & dst_q[LAST];
    assign result     = res_q[LAST];
    assign out_rrftag = rtag_q[LAST];
    assign busy       = |vld_q;

endmodule

// File: tb/tb_exunit_alu_pipe.sv
// Directed bench for exunit_alu_pipe. Four instances with LATENCY 1..4 share one stimulus stream.
module tb_exunit_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue;
    logic [31:0] ex_src1, ex_src2, pc, imm;
    logic        src_a_sel, src_b_sel;
    logic [3:0]  alu_op;
    logic        dstval;
    logic [5:0]  rrftag;
    logic [4:0]  spectag, spectagfix;
    logic        specbit, prmiss, prsuccess;

    logic [31:0] res   [1:4];
    logic [5:0]  otag  [1:4];
    logic        rrfwe [1:4];
    logic        robwe [1:4];
    logic        bsy   [1:4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exunit_alu_pipe #(.LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .issue(issue), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .pc(pc), .imm(imm), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .alu_op(alu_op), .dstval(dstval), .rrftag(rrftag), .spectag(spectag), .specbit(specbit),
        .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix), .result(res[1]),
        .out_rrftag(otag[1]), .rrf_we(rrfwe[1]), .rob_we(robwe[1]), .busy(bsy[1]));
    exunit_alu_pipe #(.LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .issue(issue), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .pc(pc), .imm(imm), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .alu_op(alu_op), .dstval(dstval), .rrftag(rrftag), .spectag(spectag), .specbit(specbit),
        .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix), .result(res[2]),
        .out_rrftag(otag[2]), .rrf_we(rrfwe[2]), .rob_we(robwe[2]), .busy(bsy[2]));
    exunit_alu_pipe #(.LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .issue(issue), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .pc(pc), .imm(imm), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .alu_op(alu_op), .dstval(dstval), .rrftag(rrftag), .spectag(spectag), .specbit(specbit),
        .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix), .result(res[3]),
        .out_rrftag(otag[3]), .rrf_we(rrfwe[3]), .rob_we(robwe[3]), .busy(bsy[3]));
    exunit_alu_pipe #(.LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .issue(issue), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .pc(pc), .imm(imm), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .alu_op(alu_op), .dstval(dstval), .rrftag(rrftag), .spectag(spectag), .specbit(specbit),
        .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix), .result(res[4]),
        .out_rrftag(otag[4]), .rrf_we(rrfwe[4]), .rob_we(robwe[4]), .busy(bsy[4]));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        asel, bsel;
        logic [31:0] pcv, immv;
        logic        dst;
        logic [31:0] exp;
    } vec_t;

    // Advance to just after the next rising edge. This is the start of a new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue = 0; ex_src1 = 0; ex_src2 = 0; pc = 0; imm = 0;
        src_a_sel = 0; src_b_sel = 0; alu_op = 0; dstval = 0; rrftag = 0;
        spectag = 0; specbit = 0; prmiss = 0; prsuccess = 0; spectagfix = 0;
    endtask

    task automatic drive_add(input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                             input logic spec, input logic [4:0] stag);
        issue = 1; alu_op = 4'd0; ex_src1 = a; ex_src2 = b; src_a_sel = 0; src_b_sel = 0;
        dstval = 1; rrftag = tag; specbit = spec; spectag = stag;
    endtask

    task automatic flush();
        idle();
        repeat (6) step();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step(); step();
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (robwe[k] !== 1'b0 || rrfwe[k] !== 1'b0 || bsy[k] !== 1'b0 || res[k] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset L%0d: rob_we=%b rrf_we=%b busy=%b result=%h, want 0 0 0 0",
                         k, robwe[k], rrfwe[k], bsy[k], res[k]);
            end
        end
        reset = 0;
        step();
    endtask

    task automatic test_add();
        drive_add(32'd5, 32'd7, 6'd3, 1'b0, 5'd0);
        step();
        idle();
        n_cmp++;
        if (robwe[1] !== 1'b1 || res[1] !== 32'd12 || otag[1] !== 6'd3) begin
            n_bad++;
            $display("FAIL add_l1: rob_we=%b result=%0d tag=%0d, want 1 12 3", robwe[1], res[1], otag[1]);
        end
        n_cmp++;
        if (robwe[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL add_l2_early: rob_we=%b want 0", robwe[2]);
        end
        step();
        n_cmp++;
        if (robwe[2] !== 1'b1 || rrfwe[2] !== 1'b1 || res[2] !== 32'd12 || otag[2] !== 6'd3) begin
            n_bad++;
            $display("FAIL add_l2: rob_we=%b rrf_we=%b result=%0d tag=%0d, want 1 1 12 3",
                     robwe[2], rrfwe[2], res[2], otag[2]);
        end
        step();
        n_cmp++;
        if (robwe[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL add_l2_late: rob_we=%b want 0", robwe[2]);
        end
        flush();
    endtask

    task automatic test_ops();
        vec_t v [14];
        v[0]  = '{4'd1,  32'h0,        32'h1,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'hFFFFFFFF};
        v[1]  = '{4'd7,  32'h80000000, 32'h4,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'hF8000000};
        v[2]  = '{4'd8,  32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h1};
        v[3]  = '{4'd9,  32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h0};
        v[4]  = '{4'd0,  32'h55,       32'h77,       1'b1, 1'b1, 32'h100, 32'h4, 1'b1, 32'h104};
        v[5]  = '{4'd0,  32'h2,        32'h3,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h5};
        v[6]  = '{4'd2,  32'hF0F0,     32'hFF00,     1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'hF000};
        v[7]  = '{4'd3,  32'hF0F0,     32'hFF00,     1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'hFFF0};
        v[8]  = '{4'd4,  32'hF0F0,     32'hFF00,     1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h0FF0};
        v[9]  = '{4'd5,  32'h1,        32'd33,       1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h2};
        v[10] = '{4'd6,  32'h80000000, 32'h4,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h08000000};
        v[11] = '{4'd10, 32'h9,        32'h1234,     1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h1234};
        v[12] = '{4'd13, 32'h5,        32'h5,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h0};
        v[13] = '{4'd0,  32'hFFFFFFFF, 32'h2,        1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h1};
        for (int i = 0; i < 14; i++) begin
            issue = 1; alu_op = v[i].op; ex_src1 = v[i].a; ex_src2 = v[i].b;
            src_a_sel = v[i].asel; src_b_sel = v[i].bsel; pc = v[i].pcv; imm = v[i].immv;
            dstval = v[i].dst; rrftag = 6'(i); specbit = 0; spectag = 0;
            step();
            idle();
            step();
            n_cmp++;
            if (robwe[2] !== 1'b1 || rrfwe[2] !== v[i].dst || res[2] !== v[i].exp || otag[2] !== 6'(i)) begin
                n_bad++;
                $display("FAIL op_vec%0d: rob_we=%b rrf_we=%b result=%h tag=%0d, want 1 %b %h %0d",
                         i, robwe[2], rrfwe[2], res[2], otag[2], v[i].dst, v[i].exp, i);
            end
        end
        flush();
    endtask

    task automatic test_spec_kill();
        // A mispredict one cycle after issue kills the entry in flight.
        drive_add(32'd1, 32'd1, 6'd8, 1'b1, 5'b00100);
        step();
        idle(); prmiss = 1; spectagfix = 5'b00100;
        #1;
        n_cmp++;
        if (bsy[3] !== 1'b1) begin n_bad++; $display("FAIL kill_busy_c1: busy=%b want 1", bsy[3]); end
        step();
        idle();
        n_cmp++;
        if (bsy[3] !== 1'b0) begin n_bad++; $display("FAIL kill_busy_c2: busy=%b want 0", bsy[3]); end
        step();
        n_cmp++;
        if (robwe[3] !== 1'b0) begin n_bad++; $display("FAIL kill_wb_c3: rob_we=%b want 0", robwe[3]); end
        flush();

        // A non-speculative op issued during the mispredict survives, even with a matching tag.
        drive_add(32'd1, 32'd1, 6'd8, 1'b1, 5'b00100);
        step();
        drive_add(32'd1, 32'd1, 6'd9, 1'b0, 5'b00100); prmiss = 1; spectagfix = 5'b00100;
        step();
        idle();
        step();
        n_cmp++;
        if (robwe[3] !== 1'b0) begin n_bad++; $display("FAIL kill_mix_c3: rob_we=%b want 0", robwe[3]); end
        step();
        n_cmp++;
        if (robwe[3] !== 1'b1 || res[3] !== 32'd2 || otag[3] !== 6'd9) begin
            n_bad++;
            $display("FAIL nonspec_c4: rob_we=%b result=%0d tag=%0d, want 1 2 9", robwe[3], res[3], otag[3]);
        end
        flush();
    endtask

    task automatic test_spec_nokill();
        // A mispredict with a non-matching tag leaves the entry alone.
        drive_add(32'd3, 32'd4, 6'd5, 1'b1, 5'b00100);
        step();
        idle(); prmiss = 1; spectagfix = 5'b00010;
        step();
        idle();
        step();
        n_cmp++;
        if (robwe[3] !== 1'b1 || res[3] !== 32'd7 || otag[3] !== 6'd5) begin
            n_bad++;
            $display("FAIL nomatch_c3: rob_we=%b result=%0d tag=%0d, want 1 7 5", robwe[3], res[3], otag[3]);
        end
        flush();

        // A correct prediction clears the spec bit, so later matching mispredicts are ignored.
        drive_add(32'd3, 32'd4, 6'd5, 1'b1, 5'b00100);
        step();
        idle(); prsuccess = 1; spectagfix = 5'b00100;
        step();
        idle(); prmiss = 1; spectagfix = 5'b00100;
        step();
        #1;
        n_cmp++;
        if (robwe[3] !== 1'b1 || rrfwe[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL success_then_miss: rob_we=%b rrf_we=%b want 1 1", robwe[3], rrfwe[3]);
        end
        flush();

        // A correct prediction in the issue cycle clears the spec bit on entry.
        drive_add(32'd3, 32'd4, 6'd5, 1'b1, 5'b00100); prsuccess = 1; spectagfix = 5'b00100;
        step();
        idle(); prmiss = 1; spectagfix = 5'b00100;
        step(); step();
        #1;
        n_cmp++;
        if (robwe[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_success: rob_we=%b want 1", robwe[3]);
        end
        flush();

        // When both resolve in the same cycle, the mispredict wins.
        drive_add(32'd3, 32'd4, 6'd5, 1'b1, 5'b00100);
        step();
        idle(); prmiss = 1; prsuccess = 1; spectagfix = 5'b00100;
        step();
        idle();
        step();
        n_cmp++;
        if (robwe[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_priority: rob_we=%b want 0", robwe[3]);
        end
        flush();
    endtask

    task automatic test_wb_kill();
        drive_add(32'd1, 32'd2, 6'd6, 1'b1, 5'b00001);
        step();
        idle();
        step();
        drive_add(32'd9, 32'd9, 6'd7, 1'b1, 5'b00001); prmiss = 1; spectagfix = 5'b00001;
        #1;
        n_cmp++;
        if (robwe[2] !== 1'b0 || rrfwe[2] !== 1'b0 || bsy[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL wb_kill: rob_we=%b rrf_we=%b busy=%b want 0 0 1", robwe[2], rrfwe[2], bsy[2]);
        end
        step();
        idle();
        n_cmp++;
        if (bsy[2] !== 1'b0) begin n_bad++; $display("FAIL issue_kill_busy: busy=%b want 0", bsy[2]); end
        step();
        n_cmp++;
        if (robwe[2] !== 1'b0) begin n_bad++; $display("FAIL issue_kill_wb: rob_we=%b want 0", robwe[2]); end
        flush();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 12; i++) begin
            idle();
            if (i < 8) drive_add(32'(i), 32'd100, 6'(i), 1'b0, 5'd0);
            reset = (i == 5);
            #1;
            if (i == 4 || i == 5 || i == 10) begin
                n_cmp++;
                if (robwe[4] !== 1'b1 || otag[4] !== 6'(i - 4) || res[4] !== 32'(96 + i)) begin
                    n_bad++;
                    $display("FAIL rst_wb_c%0d: rob_we=%b tag=%0d result=%0d, want 1 %0d %0d",
                             i, robwe[4], otag[4], res[4], i - 4, 96 + i);
                end
            end else if (i >= 6 && i <= 9) begin
                n_cmp++;
                if (robwe[4] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rst_nowb_c%0d: rob_we=%b want 0", i, robwe[4]);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (bsy[4] !== 1'b0) begin n_bad++; $display("FAIL rst_busy_c6: busy=%b want 0", bsy[4]); end
            end
            step();
        end
        reset = 0;
        flush();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 13; i++) begin
            idle();
            if (i < 8) drive_add(32'd200, 32'(i), 6'(i + 16), 1'b0, 5'd0);
            #1;
            n_cmp++;
            if (i >= 4 && i < 12) begin
                if (robwe[4] !== 1'b1 || otag[4] !== 6'(i + 12) || res[4] !== 32'(196 + i)) begin
                    n_bad++;
                    $display("FAIL b2b_c%0d: rob_we=%b tag=%0d result=%0d, want 1 %0d %0d",
                             i, robwe[4], otag[4], res[4], i + 12, 196 + i);
                end
            end else if (robwe[4] !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_idle_c%0d: rob_we=%b want 0", i, robwe[4]);
            end
            step();
        end
        flush();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_add();
        test_ops();
        test_spec_kill();
        test_spec_nokill();
        test_wb_kill();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
